axi_mmio_txn_mon: RTL

Parametrised passive transaction monitor for NUM_PORTS snooped AXI-Lite/AXI4-MM MMIO ports in the port gasket. It is the checking successor to the pure signal-tap binds.
- Per port: counts completed reads and writes, tracks outstanding depth, counts error responses, and detects handshake-stability, underflow, overflow and timeout violations.
- Reports violations as per-port sticky flags plus a first-error capture register.
- Never drives the snooped buses.

---
 rtl/axi_mmio_txn_mon.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/axi_mmio_txn_mon.sv
// Passive monitor for NUM_PORTS snooped AXI MMIO ports: completion/error counters, outstanding depth,
// sticky violation flags and first-error capture. Timeout detection (code 6) exists only with AXI_MMIO_MON_TIMEOUT_EN.
module axi_mmio_txn_mon #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 18,
  parameter int CNT_W       = 32,
  parameter int MAX_OUTST   = 16,
  parameter int TIMEOUT_CYC = 4096,
  localparam int OST_W      = $clog2(MAX_OUTST + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic [NUM_PORTS-1:0]        awvalid, awready, arvalid, arready,
  input  logic [NUM_PORTS-1:0]        bvalid, bready, rvalid, rready, rlast,
  input  logic [NUM_PORTS*ADDR_W-1:0] awaddr, araddr,
  input  logic [NUM_PORTS*2-1:0]      bresp, rresp,
  output logic [NUM_PORTS*CNT_W-1:0]  wr_cnt, rd_cnt, err_resp_cnt,
  output logic [NUM_PORTS*OST_W-1:0]  wr_outst, rd_outst,
  output logic [NUM_PORTS*8-1:0]      err_sticky,
  output logic [NUM_PORTS-1:0]        err_pulse,
  output logic                        first_err_valid,
  output logic [2:0]                  first_err_port,
  output logic [2:0]                  first_err_code,
  output logic [ADDR_W-1:0]           first_err_addr
);

  localparam logic [OST_W-1:0] OST_MAX = OST_W'(MAX_OUTST);

  // Handshake: a transfer happens in a cycle where valid and ready are both 1; valid
  // raised without ready is a stall and must hold valid and address until accepted.
  logic [NUM_PORTS*8-1:0]      codes_all;
  logic [NUM_PORTS*ADDR_W-1:0] aw_hist_addr, ar_hist_addr;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic              aw_hs, ar_hs, b_hs, r_hs, rl_hs;
    logic [ADDR_W-1:0] awaddr_p, araddr_p, aw_addr_q, ar_addr_q;
    logic              aw_stall_q, ar_stall_q;
    logic [OST_W-1:0]  wr_q, rd_q, wr_d, rd_d;
    logic [CNT_W-1:0]  wr_cnt_q, rd_cnt_q, err_cnt_q;
    logic [7:0]        codes, sticky_q;
    logic              pulse_q, tmo_hit;

    assign aw_hs    = awvalid[p] & awready[p];
    assign ar_hs    = arvalid[p] & arready[p];
    assign b_hs     = bvalid[p] & bready[p];
    assign r_hs     = rvalid[p] & rready[p];
    assign rl_hs    = r_hs & rlast[p];
    assign awaddr_p = awaddr[p*ADDR_W +: ADDR_W];
    assign araddr_p = araddr[p*ADDR_W +: ADDR_W];

    always_comb begin
      codes    = '0;
      codes[1] = aw_stall_q & (~awvalid[p] | (awaddr_p != aw_addr_q));
      codes[2] = ar_stall_q & (~arvalid[p] | (araddr_p != ar_addr_q));
      codes[3] = b_hs & ~aw_hs & (wr_q == '0);
      codes[4] = rl_hs & ~ar_hs & (rd_q == '0);
      codes[5] = (aw_hs & ~b_hs & (wr_q == OST_MAX)) | (ar_hs & ~rl_hs & (rd_q == OST_MAX));
      codes[6] = tmo_hit;
      wr_d = wr_q;
      if (aw_hs && !b_hs && wr_q != OST_MAX)  wr_d = wr_q + OST_W'(1);
      else if (b_hs && !aw_hs && wr_q != '0) wr_d = wr_q - OST_W'(1);
      rd_d = rd_q;
      if (ar_hs && !rl_hs && rd_q != OST_MAX)  rd_d = rd_q + OST_W'(1);
      else if (rl_hs && !ar_hs && rd_q != '0) rd_d = rd_q - OST_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        aw_stall_q <= 1'b0;
        ar_stall_q <= 1'b0;
        aw_addr_q  <= '0;
        ar_addr_q  <= '0;
        wr_q       <= '0;
        rd_q       <= '0;
        wr_cnt_q   <= '0;
        rd_cnt_q   <= '0;
        err_cnt_q  <= '0;
        sticky_q   <= '0;
        pulse_q    <= 1'b0;
      end else if (clear) begin
        aw_stall_q <= 1'b0;
        ar_stall_q <= 1'b0;
        aw_addr_q  <= '0;
        ar_addr_q  <= '0;
        wr_q       <= '0;
        rd_q       <= '0;
        wr_cnt_q   <= '0;
        rd_cnt_q   <= '0;
        err_cnt_q  <= '0;
        sticky_q   <= '0;
        pulse_q    <= 1'b0;
      end else begin
        aw_stall_q <= awvalid[p] & ~awready[p];
        ar_stall_q <= arvalid[p] & ~arready[p];
        aw_addr_q  <= awaddr_p;
        ar_addr_q  <= araddr_p;
        wr_q       <= wr_d;
        rd_q       <= rd_d;
        wr_cnt_q   <= wr_cnt_q + CNT_W'(b_hs);
        rd_cnt_q   <= rd_cnt_q + CNT_W'(rl_hs);
        err_cnt_q  <= err_cnt_q + CNT_W'(b_hs & (bresp[2*p +: 2] != 2'b00))
                                + CNT_W'(r_hs & (rresp[2*p +: 2] != 2'b00));
        sticky_q   <= sticky_q | codes;
        pulse_q    <= |codes;
      end
    end

`ifdef AXI_MMIO_MON_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);
    logic [TMR_W-1:0] tmr_q;
    logic             tmr_clr;

    // The timer saturates at TMR_MAX, so the hit condition can only recur after a clear.
    assign tmr_clr = b_hs | rl_hs | ((wr_q == '0) && (rd_q == '0));
    assign tmo_hit = ~tmr_clr & (tmr_q == TMR_MAX - TMR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  tmr_q <= '0;
      else if (clear || tmr_clr)   tmr_q <= '0;
      else if (tmr_q != TMR_MAX)   tmr_q <= tmr_q + TMR_W'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign wr_cnt[p*CNT_W +: CNT_W]         = wr_cnt_q;
    assign rd_cnt[p*CNT_W +: CNT_W]         = rd_cnt_q;
    assign err_resp_cnt[p*CNT_W +: CNT_W]   = err_cnt_q;
    assign wr_outst[p*OST_W +: OST_W]       = wr_q;
    assign rd_outst[p*OST_W +: OST_W]       = rd_q;
    assign err_sticky[p*8 +: 8]             = sticky_q;
    assign err_pulse[p]                     = pulse_q;
    assign codes_all[p*8 +: 8]              = codes;
    assign aw_hist_addr[p*ADDR_W +: ADDR_W] = aw_addr_q;
    assign ar_hist_addr[p*ADDR_W +: ADDR_W] = ar_addr_q;
  end

`ifndef AXI_MMIO_MON_TIMEOUT_EN
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

  // Scan from the highest port/code down so the lowest port, then lowest code, wins.
  logic              sel_valid;
  logic [2:0]        sel_port, sel_code;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    sel_valid = 1'b0;
    sel_port  = '0;
    sel_code  = '0;
    sel_addr  = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      for (int k = 7; k >= 0; k--) begin
        if (codes_all[p*8 + k]) begin
          sel_valid = 1'b1;
          sel_port  = 3'(p);
          sel_code  = 3'(k);
          sel_addr  = (k == 1) ? aw_hist_addr[p*ADDR_W +: ADDR_W] :
                      (k == 2) ? ar_hist_addr[p*ADDR_W +: ADDR_W] : '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_valid <= 1'b0;
      first_err_port  <= '0;
      first_err_code  <= '0;
      first_err_addr  <= '0;
    end else if (clear) begin
      first_err_valid <= 1'b0;
      first_err_port  <= '0;
      first_err_code  <= '0;
      first_err_addr  <= '0;
    end else if (!first_err_valid && sel_valid) begin
      first_err_valid <= 1'b1;
      first_err_port  <= sel_port;
      first_err_code  <= sel_code;
      first_err_addr  <= sel_addr;
    end
  end

endmodule
